// File: rtl/ts_merge.sv
// ts_merge: per-port timestamp FIFOs merged round-robin into one registered ready/valid stream
module ts_merge #(
  parameter int DATA_WIDTH = 96,
  parameter int FP_WIDTH   = 8,
  parameter int NUM_PORTS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            i_ts_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_ts_data,
  input  logic [NUM_PORTS*FP_WIDTH-1:0]   i_ts_fp,
  output logic                            o_ts_valid,
  input  logic                            i_ts_ready,
  output logic [DATA_WIDTH-1:0]           o_ts_data,
  output logic [FP_WIDTH-1:0]             o_ts_fp,
  output logic [$clog2(NUM_PORTS)-1:0]    o_ts_port,
  output logic [NUM_PORTS-1:0]            o_drop,
  input  logic [NUM_PORTS-1:0]            i_drop_clr
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + FP_WIDTH;

  logic [NUM_PORTS-1:0] push, pop, full, nonempty;
  logic [EW-1:0]        head [NUM_PORTS];
  logic [PW-1:0]        gnt, idx, rr_q, rr_d;
  logic                 any, slot_free;
  logic                 valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [FP_WIDTH-1:0]  fp_q;
  logic [PW-1:0]        port_q;
  logic [NUM_PORTS-1:0] drop_q, drop_d;

  assign slot_free = !valid_q || i_ts_ready;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    assign full[p]     = cnt_q == CW'(FIFO_DEPTH);
    assign nonempty[p] = cnt_q != '0;
    assign push[p]     = i_ts_valid[p] && !full[p];
    assign pop[p]      = slot_free && any && gnt == PW'(p);
    assign head[p]     = mem_q[rd_q];
    // Circular buffer; occupancy moves by push minus pop so simultaneous ops cancel
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push[p]) begin
          mem_q[wr_q] <= {i_ts_data[p*DATA_WIDTH +: DATA_WIDTH], i_ts_fp[p*FP_WIDTH +: FP_WIDTH]};
          wr_q        <= wr_q + AW'(1);
        end
        if (pop[p]) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_q + CW'(push[p]) - CW'(pop[p]);
      end
    end
  end

  // Round-robin search from rr_q; iterating backwards lets the nearest non-empty port win
  always_comb begin
    gnt = rr_q;
    any = 1'b0;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_q) + i) % NUM_PORTS);
      if (nonempty[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
    rr_d   = any ? PW'((int'(gnt) + 1) % NUM_PORTS) : rr_q;
    drop_d = (drop_q & ~i_drop_clr) | (i_ts_valid & full);
  end

  // Output register, arbitration pointer and sticky drop flags
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      fp_q    <= '0;
      port_q  <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
    end else begin
      drop_q <= drop_d;
      if (slot_free) begin
        valid_q <= any;
        rr_q    <= rr_d;
        if (any) begin
          {data_q, fp_q} <= head[gnt];
          port_q         <= gnt;
        end
      end
    end
  end

  assign o_ts_valid = valid_q;
  assign o_ts_data  = data_q;
  assign o_ts_fp    = fp_q;
  assign o_ts_port  = port_q;
  assign o_drop     = drop_q;
endmodule

// File: tb/tb_ts_merge.sv
// tb_ts_merge: randomized and directed checks of ts_merge against a queue-based reference model
module tb_ts_merge;
  localparam int NP = 8, DW = 96, FW = 8, DEP = 4;
  localparam int VW = 1 + 3 + FW + DW + NP;
  typedef logic [DW+FW-1:0] ent_t;

  logic clk = 1'b0, rst = 1'b1, ready = 1'b1;
  logic [NP-1:0] vld = '0, clr = '0;
  logic [NP*DW-1:0] dat = '0;
  logic [NP*FW-1:0] fp = '0;
  logic o_ts_valid;
  logic [DW-1:0] o_ts_data;
  logic [FW-1:0] o_ts_fp;
  logic [2:0] o_ts_port;
  logic [NP-1:0] o_drop;

  int n_chk = 0, n_fail = 0, cyc = 0;

  ent_t mq[NP][$];
  logic m_ov;
  ent_t m_out;
  logic [2:0] m_port;
  int m_rr;
  logic [NP-1:0] m_drop;

  ts_merge dut (
    .clk(clk), .rst(rst), .i_ts_valid(vld), .i_ts_data(dat), .i_ts_fp(fp),
    .o_ts_valid(o_ts_valid), .i_ts_ready(ready), .o_ts_data(o_ts_data), .o_ts_fp(o_ts_fp),
    .o_ts_port(o_ts_port), .o_drop(o_drop), .i_drop_clr(clr)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {o_ts_valid, o_ts_port, o_ts_fp, o_ts_data, o_drop};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_ov, m_port, m_out[FW-1:0], m_out[DW+FW-1:FW], m_drop};
  endfunction

  task automatic model_step();
    int sz[NP];
    int g;
    logic [NP-1:0] disc;
    if (rst) begin
      for (int p = 0; p < NP; p++) mq[p].delete();
      m_ov = 1'b0; m_out = '0; m_port = '0; m_rr = 0; m_drop = '0;
      return;
    end
    for (int p = 0; p < NP; p++) sz[p] = mq[p].size();
    if (!m_ov || ready) begin
      g = -1;
      for (int k = 0; k < NP; k++) if (g < 0 && sz[(m_rr + k) % NP] > 0) g = (m_rr + k) % NP;
      m_ov = g >= 0;
      if (g >= 0) begin
        m_out = mq[g].pop_front();
        m_port = 3'(g);
        m_rr = (g + 1) % NP;
      end
    end
    disc = '0;
    for (int p = 0; p < NP; p++)
      if (vld[p]) begin
        if (sz[p] < DEP) mq[p].push_back({dat[p*DW +: DW], fp[p*FW +: FW]});
        else disc[p] = 1'b1;
      end
    m_drop = (m_drop & ~clr) | disc;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = '0; clr = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic put(input int p, input logic [DW-1:0] d, input logic [FW-1:0] f);
    dat[p*DW +: DW] = d;
    fp[p*FW +: FW] = f;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '1; clr = '1; ready = 1'b1;
    step();
    step();
    rst = 1'b0; vld = '0; clr = '0;
    n_chk++;
    if (o_ts_valid !== 1'b0 || o_drop !== '0 || o_ts_data !== '0 || o_ts_fp !== '0 || o_ts_port !== '0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b drop=%h data=%h fp=%h port=%0d exp all zero", o_ts_valid, o_drop, o_ts_data, o_ts_fp, o_ts_port);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_single_strobe();
    do_reset();
    ready = 1'b1;
    vld = 8'h04;
    put(2, 96'hA5, 8'h3C);
    step();
    vld = '0;
    n_chk++;
    if (o_ts_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c1 got valid %b exp 0", o_ts_valid);
    end
    step();
    n_chk++;
    if (o_ts_valid !== 1'b1 || o_ts_port !== 3'd2 || o_ts_data !== 96'hA5 || o_ts_fp !== 8'h3C) begin
      n_fail++;
      $display("FAIL single_c2 got v=%b port=%0d data=%h fp=%h exp v=1 port=2 data=a5 fp=3c", o_ts_valid, o_ts_port, o_ts_data, o_ts_fp);
    end
    step();
    n_chk++;
    if (o_ts_valid !== 1'b0 || o_ts_data !== 96'hA5) begin
      n_fail++;
      $display("FAIL single_c3 got v=%b data=%h exp v=0 data=a5", o_ts_valid, o_ts_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      vld = '1;
      for (int p = 0; p < NP; p++) put(p, DW'($urandom), FW'($urandom));
      step();
      vld = '0;
      step();
      for (int i = 0; i < NP; i++) begin
        n_chk++;
        if (o_ts_valid !== 1'b1 || o_ts_port !== 3'(i) || dut_vec() !== model_vec()) begin
          n_fail++;
          $display("FAIL round_robin burst %0d slot %0d got v=%b port=%0d exp v=1 port=%0d (vec %h vs %h)", b, i, o_ts_valid, o_ts_port, i, dut_vec(), model_vec());
        end
        step();
      end
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] got5[$];
    do_reset();
    ready = 1'b0;
    vld = 8'h01;
    put(0, 96'hEE, 8'h11);
    step();
    vld = '0;
    step();
    for (int k = 1; k <= 6; k++) begin
      vld = 8'h20;
      put(5, DW'(k), FW'(k));
      step();
    end
    vld = '0;
    n_chk++;
    if (o_drop[5] !== 1'b1 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL overflow_drop got drop=%h exp bit5 set (vec %h vs %h)", o_drop, dut_vec(), model_vec());
    end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (o_ts_valid && o_ts_port == 3'd5) got5.push_back(o_ts_data);
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL overflow_drain cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
      end
    end
    n_chk++;
    if (got5.size() != 4 || got5[0] !== 96'd1 || got5[1] !== 96'd2 || got5[2] !== 96'd3 || got5[3] !== 96'd4) begin
      n_fail++;
      $display("FAIL overflow_order got %0d entries exp 1,2,3,4", got5.size());
    end
  endtask

  task automatic test_drop_collision();
    do_reset();
    ready = 1'b0;
    vld = 8'h01;
    put(0, 96'h77, 8'h22);
    step();
    vld = '0;
    step();
    for (int k = 1; k <= 4; k++) begin
      vld = 8'h20;
      put(5, DW'(k + 40), FW'(k));
      step();
    end
    vld = 8'h20;
    clr = 8'h20;
    step();
    n_chk++;
    if (o_drop[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_set_wins got %b exp 1", o_drop[5]);
    end
    vld = '0;
    step();
    n_chk++;
    if (o_drop[5] !== 1'b0 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL drop_clear got %b exp 0 (vec %h vs %h)", o_drop[5], dut_vec(), model_vec());
    end
    clr = '0;
    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL drop_drain cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    logic pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [VW-1:0] prev;
    logic [DW-1:0] xfer[$];
    do_reset();
    ready = 1'b1;
    vld = 8'b0100_1010;
    put(1, 96'h101, 8'h01);
    put(3, 96'h303, 8'h03);
    put(6, 96'h606, 8'h06);
    step();
    vld = '0;
    step();
    for (int i = 0; i < 8; i++) begin
      ready = pat[i];
      if (o_ts_valid && ready) xfer.push_back(o_ts_data);
      prev = dut_vec();
      step();
      n_chk++;
      if (dut_vec() !== model_vec() || (!ready && prev[VW-1] && dut_vec() !== prev)) begin
        n_fail++;
        $display("FAIL backpressure cyc %0d got %h exp %h prev %h", cyc, dut_vec(), model_vec(), prev);
      end
    end
    n_chk++;
    if (xfer.size() != 3 || xfer[0] !== 96'h101 || xfer[1] !== 96'h303 || xfer[2] !== 96'h606) begin
      n_fail++;
      $display("FAIL backpressure_xfers got %0d transfers exp 101,303,606", xfer.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    ready = 1'b0;
    vld = 8'h0F;
    for (int p = 0; p < 4; p++) put(p, DW'(p + 9), FW'(p));
    step();
    vld = '0;
    step();
    vld = 8'h0F;
    step();
    vld = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready = 1'b1;
    n_chk++;
    if (o_ts_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_valid got %b exp 0", o_ts_valid);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if (o_ts_valid !== 1'b0 || dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_stale cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      vld = NP'($urandom & $urandom);
      for (int w = 0; w < NP*DW/32; w++) dat[w*32 +: 32] = $urandom;
      for (int w = 0; w < NP*FW/32; w++) fp[w*32 +: 32] = $urandom;
      ready = $urandom_range(0, 3) != 0;
      clr = ($urandom_range(0, 15) == 0) ? NP'($urandom) : '0;
      rst = $urandom_range(0, 499) == 0;
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d got %h exp %h", cyc, dut_vec(), model_vec());
      end
    end
    rst = 1'b0;
    vld = '0;
    clr = '0;
  endtask

  initial begin
    test_reset();
    test_single_strobe();
    test_round_robin();
    test_overflow();
    test_drop_collision();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ts_merge.md
TS_MERGE -- requirements
Module: ts_merge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, timestamp payload width per port.
REQ-002 SHALL have parameter FP_WIDTH, default 8, fingerprint width per port.
REQ-003 SHALL have parameter NUM_PORTS, default 8, number of timestamp ports; legal range 2..16.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, per-port buffer entries; power of two, at least 2.
REQ-005 SHALL have one clock, clk, input, 1 bit; all logic on the rising edge.
REQ-006 SHALL have reset rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have i_ts_valid, input, NUM_PORTS bits: per-port timestamp strobe, no backpressure.
REQ-008 SHALL have i_ts_data, input, NUM_PORTS*DATA_WIDTH bits: port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have i_ts_fp, input, NUM_PORTS*FP_WIDTH bits: port p occupies bits [p*FP_WIDTH +: FP_WIDTH].
REQ-010 SHALL have o_ts_valid, output, 1 bit: merged stream valid.
REQ-011 SHALL have i_ts_ready, input, 1 bit: merged stream ready.
REQ-012 SHALL have o_ts_data (DATA_WIDTH), o_ts_fp (FP_WIDTH) and o_ts_port ($clog2(NUM_PORTS)) as outputs: payload, fingerprint and source port.
REQ-013 SHALL have o_drop, output, NUM_PORTS bits: sticky per-port overflow flags.
REQ-014 SHALL have i_drop_clr, input, NUM_PORTS bits: per-port clear for o_drop.

Function
REQ-015 SHALL keep one FIFO per port, FIFO_DEPTH entries, each entry holding {data, fp}.
REQ-016 SHALL write port p's FIFO when i_ts_valid[p]=1 and its registered occupancy is less than FIFO_DEPTH.
REQ-017 SHALL discard the input when i_ts_valid[p]=1 and occupancy equals FIFO_DEPTH, even if a pop occurs in the same cycle, keeping buffered entries unchanged.
REQ-018 SHALL set o_drop[p] on every discard; o_drop[p] clears only on i_drop_clr[p]=1, and a set in the same cycle wins over a clear.
REQ-019 SHALL hold the output in a single register stage: o_ts_valid, o_ts_data, o_ts_fp and o_ts_port stay stable while o_ts_valid=1 and i_ts_ready=0.
REQ-020 SHALL treat the output slot as free when o_ts_valid=0, or when o_ts_valid=1 and i_ts_ready=1.
REQ-021 SHALL, in each cycle the slot is free, grant one non-empty FIFO using round-robin search starting at pointer rr_ptr, pop its head and load the output register at the clock edge.
REQ-022 SHALL set rr_ptr to (granted port + 1) mod NUM_PORTS after each grant, and leave it unchanged when there is no grant.
REQ-023 SHALL deassert o_ts_valid at the edge when the slot is free and all FIFOs are empty; o_ts_data, o_ts_fp and o_ts_port then hold their last values.
REQ-024 SHALL have a latency of 2 cycles: with all FIFOs empty and the slot free, a strobe in cycle N gives o_ts_valid=1 in cycle N+2.
REQ-025 SHALL sustain one transfer per cycle while i_ts_ready=1 and any FIFO is non-empty.
REQ-026 SHALL let a FIFO push and pop in the same cycle when occupancy is between 1 and FIFO_DEPTH-1, leaving occupancy unchanged.
REQ-027 SHALL preserve per-port order; ordering between different ports is decided by arbitration only.

Reset
REQ-028 SHALL, while rst=1, empty all FIFOs and set o_ts_valid=0, o_ts_data=0, o_ts_fp=0, o_ts_port=0, o_drop=0 and rr_ptr=0.
REQ-029 SHALL ignore i_ts_valid and i_drop_clr in any cycle where rst=1.
REQ-030 SHALL, on reset mid-operation, lose buffered and pending entries without emitting them; the first cycle after rst falls behaves as after power-up.

Verification
REQ-031 SHALL test a single strobe: after reset, i_ts_valid=8'h04, data=96'hA5, fp=8'h3C in cycle 0 -> o_ts_valid=1, o_ts_port=2, data=96'hA5, fp=8'h3C in cycle 2, then o_ts_valid=0 in cycle 3 with ready held at 1.
REQ-032 SHALL test round-robin: all 8 ports strobe in one cycle, ready=1 -> ports emitted 0,1,...,7 on consecutive cycles; a repeat of the same burst is also emitted 0..7.
REQ-033 SHALL test overflow: ready=0, port 5 strobed 6 times with data 1..6 -> o_drop[5]=1; after ready=1 the block emits exactly 1,2,3,4.
REQ-034 SHALL test backpressure: ready toggled 1,0,0,1 while 3 ports are pending -> output stays stable during ready=0, with no loss and no duplicates.
REQ-035 SHALL test clear/set collision: i_drop_clr[5]=1 in the same cycle as a discard on port 5 -> o_drop[5] stays 1; a clear alone in the next cycle -> 0.
REQ-036 SHALL test reset mid-burst: rst=1 for 1 cycle with 4 entries buffered -> o_ts_valid=0 the next cycle and no stale entry is emitted afterwards.
